// File: rtl/fixed_requant_pkg.sv
// Shared sizing helpers for the fixed-point requantizer pipeline.
package fixed_requant_pkg;

  function automatic int shift_amt(input int in_frac, input int out_frac);
    return in_frac - out_frac;
  endfunction

  // One guard bit above the (possibly left-extended) input keeps the rounding add exact.
  function automatic int int_width(input int in_w, input int shift);
    return in_w + ((shift < 0) ? -shift : 0) + 1;
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

  function automatic int lanes(input int dim_0, input int dim_1);
    return dim_0 * dim_1;
  endfunction

endpackage

// File: rtl/fixed_requant_pipe_round_sat.sv
// Single-lane combinational requantizer: round-half-up, rescale, signed saturate.
module fixed_round_sat
  import fixed_requant_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 4
) (
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] data_out,
  output logic             saturated
);

  localparam int SHIFT  = shift_amt(IN_FRAC, OUT_FRAC);
  localparam int INT_W  = int_width(IN_W, SHIFT);
  localparam int RSH    = (SHIFT > 0) ? SHIFT : 0;
  localparam int LSH    = (SHIFT < 0) ? -SHIFT : 0;
  localparam int RND_SH = (RSH > 0) ? RSH - 1 : 0;

  // Zero when no fraction bits are dropped, so one datapath covers every SHIFT sign.
  localparam logic signed [INT_W-1:0] RND_C =
    (RSH > 0) ? (INT_W'(1) << RND_SH) : INT_W'(0);

  localparam longint SAT_HI = sat_max(OUT_W);
  localparam longint SAT_LO = sat_min(OUT_W);

  logic signed [INT_W-1:0] ext;
  logic signed [INT_W-1:0] rounded;
  logic signed [INT_W-1:0] scaled;
  longint                  wide;

  always_comb begin
    ext       = {{(INT_W-IN_W){data_in[IN_W-1]}}, data_in};
    rounded   = ext + RND_C;
    scaled    = (rounded >>> RSH) <<< LSH;
    wide      = longint'(scaled);
    saturated = 1'b0;
    data_out  = OUT_W'(wide);
    if (wide > SAT_HI) begin
      saturated = 1'b1;
      data_out  = OUT_W'(SAT_HI);
    end else if (wide < SAT_LO) begin
      saturated = 1'b1;
      data_out  = OUT_W'(SAT_LO);
    end
  end

endmodule

// File: rtl/fixed_requant_pipe.sv
// Two-stage requantizer pipeline with valid/ready backpressure.
// Optional saturation counter port enabled by `define FIXED_REQUANT_SAT_COUNT_EN.
module fixed_requant_pipe
  import fixed_requant_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = DATA_IN_0_PARALLELISM_DIM_0,
  parameter int DATA_OUT_0_PARALLELISM_DIM_1 = DATA_IN_0_PARALLELISM_DIM_1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_OUT_0_PARALLELISM_DIM_0*DATA_OUT_0_PARALLELISM_DIM_1-1:0],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
`ifdef FIXED_REQUANT_SAT_COUNT_EN
  ,
  output logic [15:0]                       sat_count
`endif
);

  localparam int IN_W    = DATA_IN_0_PRECISION_0;
  localparam int OUT_W   = DATA_OUT_0_PRECISION_0;
  localparam int LANES   = lanes(DATA_IN_0_PARALLELISM_DIM_0, DATA_IN_0_PARALLELISM_DIM_1);

  if ((DATA_IN_0_PARALLELISM_DIM_0 != DATA_OUT_0_PARALLELISM_DIM_0) ||
      (DATA_IN_0_PARALLELISM_DIM_1 != DATA_OUT_0_PARALLELISM_DIM_1)) begin : g_par_mismatch
    $error("fixed_requant_pipe: input and output parallelism must match");
  end

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [IN_W-1:0]  s1_data_q [LANES-1:0];
  logic [IN_W-1:0]  s1_data_d [LANES-1:0];
  logic [OUT_W-1:0] s2_data_q [LANES-1:0];
  logic [OUT_W-1:0] s2_data_d [LANES-1:0];
  logic [OUT_W-1:0] rs_data   [LANES-1:0];
  logic [LANES-1:0] lane_sat;
  logic             s1_adv;
  logic             s2_adv;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fixed_round_sat #(
      .IN_W    (IN_W),
      .IN_FRAC (DATA_IN_0_PRECISION_1),
      .OUT_W   (OUT_W),
      .OUT_FRAC(DATA_OUT_0_PRECISION_1)
    ) u_round_sat (
      .data_in  (s1_data_q[g]),
      .data_out (rs_data[g]),
      .saturated(lane_sat[g])
    );
  end

  // Ready ripples combinationally from the output through both stages.
  always_comb begin
    s2_adv          = !s2_valid_q || data_out_0_ready;
    s1_adv          = !s1_valid_q || s2_adv;
    data_in_0_ready = s1_adv;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (s1_adv) begin
      s1_valid_d = data_in_0_valid;
      if (data_in_0_valid) s1_data_d = data_in_0;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = rs_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '{default: '0};
      s2_data_q  <= '{default: '0};
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign data_out_0       = s2_data_q;
  assign data_out_0_valid = s2_valid_q;

`ifdef FIXED_REQUANT_SAT_COUNT_EN
  localparam int unsigned LANES_U = LANES;

  logic [15:0] sat_count_q, sat_count_d;
  logic [16:0] sat_sum;

  // Counts saturated lanes of each beat entering S2; sticks at all-ones.
  always_comb begin
    sat_sum = {1'b0, sat_count_q};
    for (int unsigned i = 0; i < LANES_U; i++) begin
      sat_sum = sat_sum + 17'(lane_sat[i]);
    end
    sat_count_d = sat_count_q;
    if (s2_adv && s1_valid_q) begin
      sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`else
  logic unused_lane_sat;
  assign unused_lane_sat = |lane_sat;
`endif

endmodule

// File: tb/tb_fixed_requant_pipe.sv
// Scoreboard bench for fixed_requant_pipe: single-lane default instance plus a 4-lane instance.
module tb_fixed_requant_pipe;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] din  [0:0];
  logic        din_v, din_r;
  logic [7:0]  dout [0:0];
  logic        dout_v, dout_r;

  logic [15:0] m_din  [3:0];
  logic        m_din_v, m_din_r;
  logic [7:0]  m_dout [3:0];
  logic        m_dout_v, m_dout_r;

`ifdef FIXED_REQUANT_SAT_COUNT_EN
  logic [15:0] sat_cnt, m_sat_cnt;
`endif

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  fixed_requant_pipe #(
    .DATA_IN_0_PRECISION_0 (16),
    .DATA_IN_0_PRECISION_1 (8),
    .DATA_OUT_0_PRECISION_0(8),
    .DATA_OUT_0_PRECISION_1(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in_0       (din),
    .data_in_0_valid (din_v),
    .data_in_0_ready (din_r),
    .data_out_0      (dout),
    .data_out_0_valid(dout_v),
    .data_out_0_ready(dout_r)
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    ,
    .sat_count       (sat_cnt)
`endif
  );

  fixed_requant_pipe #(
    .DATA_IN_0_PARALLELISM_DIM_0 (4),
    .DATA_OUT_0_PARALLELISM_DIM_0(4)
  ) m_dut (
    .clk             (clk),
    .rst             (rst),
    .data_in_0       (m_din),
    .data_in_0_valid (m_din_v),
    .data_in_0_ready (m_din_r),
    .data_out_0      (m_dout),
    .data_out_0_valid(m_dout_v),
    .data_out_0_ready(m_dout_r)
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    ,
    .sat_count       (m_sat_cnt)
`endif
  );

  // Reference: Q8.8 -> Q4.4 with +0.5 LSB rounding and clamp.
  function automatic logic [7:0] ref_q(input logic [15:0] x);
    int v;
    v = int'($signed(x)) + 8;
    v = v >>> 4;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; din_v = 1'b0; dout_r = 1'b1; din[0] = '0;
    m_din_v = 1'b0; m_dout_r = 1'b1; m_din = '{default: '0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (dout_v !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", dout_v); end
    total++; if (dout[0] !== 8'h00) begin bad++; $display("FAIL reset_data: got %h exp 00", dout[0]); end
    total++; if (din_r !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", din_r); end
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    total++; if (sat_cnt !== 16'd0) begin bad++; $display("FAIL reset_satcnt: got %0d exp 0", sat_cnt); end
`endif
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_vectors(input string name, input logic [15:0] vin [], input logic [7:0] vexp []);
    int n, sent, got;
    n = vin.size(); sent = 0; got = 0;
    dout_r = 1'b1;
    for (int k = 0; k < 40 && got < n; k++) begin
      @(posedge clk); #1;
      din_v = (sent < n);
      if (sent < n) din[0] = vin[sent];
      @(negedge clk);
      if (dout_v && dout_r) begin
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL %s_extra: got %h exp none", name, dout[0]);
        end else begin
          e = sbq.pop_front();
          if (dout[0] !== e.d) begin bad++; $display("FAIL %s_data: got %h exp %h", name, dout[0], e.d); end
          total++;
          if (cyc - e.c !== 2) begin bad++; $display("FAIL %s_latency: got %0d exp 2", name, cyc - e.c); end
        end
        got++;
      end
      if (din_v && din_r) begin
        sbq.push_back('{vexp[sent], cyc});
        sent++;
      end
    end
    din_v = 1'b0;
    total++; if (got != n) begin bad++; $display("FAIL %s_count: got %0d exp %0d", name, got, n); end
  endtask

  task automatic test_rounding();
    logic [15:0] vin [];
    logic [7:0]  vexp [];
    vin  = '{16'h0018, 16'h0008, 16'hFFF8, 16'hFFE8};
    vexp = '{8'h02, 8'h01, 8'h00, 8'hFF};
    run_vectors("round", vin, vexp);
  endtask

  task automatic test_saturation();
    logic [15:0] vin [];
    logic [7:0]  vexp [];
    vin  = '{16'h7FFF, 16'h8000, 16'h0800};
    vexp = '{8'h7F, 8'h80, 8'h7F};
    run_vectors("sat", vin, vexp);
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    total++; if (sat_cnt !== 16'd3) begin bad++; $display("FAIL sat_count: got %0d exp 3", sat_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic exp_r;
    sent = 0; got = 0;
    for (int k = 0; k < 300 && got < 10; k++) begin
      @(posedge clk); #1;
      dout_r = ((k % 4) == 3);
      din_v  = (sent < 10);
      din[0] = 16'((sent + 1) * 16);
      @(negedge clk);
      exp_r = !(sbq.size() == 2 && !dout_r);
      total++;
      if (din_r !== exp_r) begin bad++; $display("FAIL bp_ready: got %b exp %b (cycle %0d)", din_r, exp_r, cyc); end
      if (dout_v && dout_r) begin
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL bp_extra: got %h exp none", dout[0]);
        end else begin
          e = sbq.pop_front();
          if (dout[0] !== e.d) begin bad++; $display("FAIL bp_data: got %h exp %h", dout[0], e.d); end
        end
        got++;
      end
      if (din_v && din_r) begin
        sbq.push_back('{8'(sent + 1), cyc});
        sent++;
      end
    end
    din_v = 1'b0; dout_r = 1'b1;
    total++; if (got != 10) begin bad++; $display("FAIL bp_count: got %0d exp 10", got); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (dout_v !== 1'b0) begin bad++; $display("FAIL bp_dup: got valid %b exp 0", dout_v); end
  endtask

  task automatic test_throughput();
    logic [15:0] vin [32];
    int sent, got, last;
    sent = 0; got = 0; last = 0;
    foreach (vin[i]) vin[i] = 16'($urandom);
    dout_r = 1'b1;
    for (int k = 0; k < 80 && got < 32; k++) begin
      @(posedge clk); #1;
      din_v = (sent < 32);
      if (sent < 32) din[0] = vin[sent];
      @(negedge clk);
      if (din_v) begin
        total++;
        if (din_r !== 1'b1) begin bad++; $display("FAIL tp_ready: got %b exp 1", din_r); end
      end
      if (dout_v) begin
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL tp_extra: got %h exp none", dout[0]);
        end else begin
          e = sbq.pop_front();
          if (dout[0] !== e.d) begin bad++; $display("FAIL tp_data: got %h exp %h", dout[0], e.d); end
          total++;
          if (cyc - e.c !== 2) begin bad++; $display("FAIL tp_latency: got %0d exp 2", cyc - e.c); end
        end
        if (got > 0) begin
          total++;
          if (cyc - last !== 1) begin bad++; $display("FAIL tp_gap: got %0d exp 1", cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (din_v && din_r) begin
        sbq.push_back('{ref_q(vin[sent]), cyc});
        sent++;
      end
    end
    din_v = 1'b0;
    total++; if (got != 32) begin bad++; $display("FAIL tp_count: got %0d exp 32", got); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] vin [];
    logic [7:0]  vexp [];
    int acc;
    acc = 0;
    dout_r = 1'b0;
    for (int k = 0; k < 10 && acc < 2; k++) begin
      @(posedge clk); #1;
      din_v = 1'b1; din[0] = 16'h0100;
      @(negedge clk);
      if (din_r) acc++;
    end
    @(posedge clk); #1 din_v = 1'b0;
    @(negedge clk);
    total++; if (din_r !== 1'b0) begin bad++; $display("FAIL mid_full: got ready %b exp 0", din_r); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (dout_v !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b exp 0", dout_v); end
    total++; if (din_r !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b exp 1", din_r); end
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    total++; if (sat_cnt !== 16'd0) begin bad++; $display("FAIL mid_satcnt: got %0d exp 0", sat_cnt); end
`endif
    sbq.delete();
    vin  = '{16'h0030};
    vexp = '{8'h03};
    run_vectors("post_rst", vin, vexp);
  endtask

  task automatic test_multi_lane();
    logic [7:0] mexp [3:0];
    int c0;
    logic seen;
    mexp[0] = 8'h02; mexp[1] = 8'h7F; mexp[2] = 8'h80; mexp[3] = 8'h00;
    seen = 1'b0;
    m_dout_r = 1'b1;
    @(posedge clk); #1;
    m_din[0] = 16'h0018; m_din[1] = 16'h7FFF; m_din[2] = 16'h8000; m_din[3] = 16'h0000;
    m_din_v = 1'b1;
    @(negedge clk);
    c0 = cyc;
    total++; if (m_din_r !== 1'b1) begin bad++; $display("FAIL ml_ready: got %b exp 1", m_din_r); end
    @(posedge clk); #1 m_din_v = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (m_dout_v) begin
        seen = 1'b1;
        total++;
        if (cyc - c0 !== 2) begin bad++; $display("FAIL ml_latency: got %0d exp 2", cyc - c0); end
        for (int l = 0; l < 4; l++) begin
          total++;
          if (m_dout[l] !== mexp[l]) begin bad++; $display("FAIL ml_lane%0d: got %h exp %h", l, m_dout[l], mexp[l]); end
        end
      end
      if (!seen) @(posedge clk);
    end
    if (!seen) begin total++; bad++; $display("FAIL ml_timeout: got no output exp one beat"); end
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    @(negedge clk);
    total++; if (m_sat_cnt !== 16'd2) begin bad++; $display("FAIL ml_satcnt: got %0d exp 2", m_sat_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    test_multi_lane();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_requant_pipe.md
Name: fixed_requant_pipe

Overview:
- Two-stage pipelined fixed-point requantizer with valid/ready backpressure.
- Sits directly upstream of the fixed ReLU6 activation stage and feeds it.
- Converts accumulator-format signed fixed-point (wide, fine fraction) to the activation precision, using round-half-up and signed saturation.
- Registers every lane so the downstream combinational clamp sees a flopped input.

Parameters:
- DATA_IN_0_PRECISION_0, 16, input total width (signed)
- DATA_IN_0_PRECISION_1, 8, input fraction bits
- DATA_OUT_0_PRECISION_0, 8, output total width (signed)
- DATA_OUT_0_PRECISION_1, 4, output fraction bits
- DATA_IN_0_PARALLELISM_DIM_0, 1, lanes dim 0
- DATA_IN_0_PARALLELISM_DIM_1, 1, lanes dim 1
- DATA_OUT_0_PARALLELISM_DIM_0/1, same as input; must be equal (initial assert, $error otherwise)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in_0  in  [IN_W-1:0] x LANES  input lanes, LANES = PAR_DIM_0*PAR_DIM_1
- data_in_0_valid  in  1  input beat valid
- data_in_0_ready  out  1  input beat accepted when valid&&ready
- data_out_0  out  [OUT_W-1:0] x LANES  requantized lanes
- data_out_0_valid  out  1  output beat valid
- data_out_0_ready  in  1  downstream accept

Behaviour:
- One clock. Reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset, including mid-operation, clears s1_valid and s2_valid to 0 on the next edge. In-flight beats are dropped.
  - After reset: data_out_0_valid=0, data_out_0=0, data_in_0_ready=1.
- S1 registers the raw input lanes.
- S2 registers the rounded and saturated lanes. data_out_0 and data_out_0_valid are driven from S2 regs only.
- Latency is 2 cycles with no stall. Throughput is 1 beat/cycle while data_out_0_ready=1.
- Handshake:
  - s2_adv = !s2_valid || data_out_0_ready
  - s1_adv = !s1_valid || s2_adv
  - data_in_0_ready = s1_adv (combinational through both stages; documented)
- S1 load: on s1_adv, s1_valid <= data_in_0_valid and data latched when data_in_0_valid.
- S2 load: on s2_adv, s2_valid <= s1_valid.
- When stalled (valid && !ready), data_out_0 is held stable.
- Arithmetic, per lane, with SHIFT = IN_FRAC - OUT_FRAC:
  - SHIFT>0: add 2^(SHIFT-1), then arithmetic right shift by SHIFT. This is round-half-up toward +inf.
  - SHIFT=0: value passes unchanged.
  - SHIFT<0: left shift by -SHIFT.
  - Intermediate width: INT_W = IN_W + max(0,-SHIFT) + 1, so the rounding add never overflows.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Simultaneous input accept and output drain in the same cycle: both occur, with no bubble.

Optional Feature:
- Macro FIXED_REQUANT_SAT_COUNT_EN.
- When defined:
  - Extra output port sat_count [15:0].
  - Counts the number of lanes saturated on each beat loaded into S2.
  - The count saturates at 0xFFFF; no wrap.
  - Cleared by rst.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fixed_requant_pkg holds:
  - function for SHIFT
  - function for INT_W
  - functions returning the OUT_W min and max saturation bounds
  - LANES helper
- One natural sub-module: fixed_round_sat.
  - Combinational, single lane: round, then shift, then saturate.
  - Flags `saturated` for the optional counter.
  - Instantiated per lane between S1 and S2.
- Pipeline control is kept in the parent.

Test Plan (defaults: IN 16/8, OUT 8/4, SHIFT=4, 1 lane):
- Rounding values:
  - 0x0018 -> 0x02
  - 0x0008 -> 0x01 (half rounds up)
  - 0xFFF8 -> 0x00
  - 0xFFE8 -> 0xFF
  - Each output appears exactly 2 cycles after accept.
- Saturation:
  - 0x7FFF -> 0x7F
  - 0x8000 -> 0x80
  - 0x0800 -> 0x7F
  - With FIXED_REQUANT_SAT_COUNT_EN, sat_count=3 after these beats.
- Backpressure:
  - Stream 1..10 (scaled ×16) with data_out_0_ready toggling in a 3-cycle-low/1-cycle-high pattern.
  - Output must be 1..10 in order, with no loss or duplication.
  - data_in_0_ready must be low only while both stages are full and the output is stalled.
- Full throughput: data_out_0_ready held high, valid every cycle for 32 beats -> 32 outputs on consecutive cycles starting at cycle 2.
- Reset mid-stream:
  - Assert rst with both stages full -> next cycle data_out_0_valid=0, data_in_0_ready=1, sat_count=0.
  - The first post-reset beat emerges 2 cycles after accept.
- Multi-lane: PAR_DIM_0=4, lanes {0x0018, 0x7FFF, 0x8000, 0x0000} -> {0x02, 0x7F, 0x80, 0x00} in the same beat.
